// File: rtl/status_register_unit.sv
// rtl/status_register_unit.sv - NZCV status register with exception save/restore, EX forwarding or flag-hazard stall
module status_register_unit #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             ex_valid,
    input  logic             ex_s,
    input  logic [3:0]       ex_flags,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             exc_entry,
    input  logic             exc_return,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             flag_stall,
    output logic [3:0]       saved_flags,
    output logic [CNT_W-1:0] stall_count
);

    logic [3:0]       sr_q, sr_d;
    logic [3:0]       sv_q, sv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_wr;
    logic             hazard;
    logic [3:0]       flags_out;

    always_comb begin
        ex_wr  = ex_valid && ex_s;
        // AL (1110) and 1111 never read the flags, so they never hazard
        hazard = id_valid && (id_cond[3:1] != 3'b111) && ex_wr;

        flag_stall = (FWD_EN == 0) ? hazard : 1'b0;
        flags_out  = ((FWD_EN != 0) && ex_wr) ? ex_flags : sr_q;

        sr_d  = sr_q;
        sv_d  = sv_q;
        cnt_d = cnt_q;
        if (!freeze) begin
            // entry wins over a simultaneous return; return squashes the EX write
            if (exc_return && !exc_entry) begin
                sr_d = sv_q;
            end else if (ex_wr) begin
                sr_d = ex_flags;
            end
            if (exc_entry) begin
                sv_d = sr_d;
            end
            if (flag_stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= 4'b0000;
            sv_q  <= 4'b0000;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            sv_q  <= sv_d;
            cnt_q <= cnt_d;
        end
    end

    assign {n, z, c, v} = flags_out;
    assign saved_flags  = sv_q;
    assign stall_count  = cnt_q;

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 Parameter FWD_EN, default 1: 1 = forward same-cycle EX flags to the consumer; 0 = stall on flag hazard instead.
REQ-002 Parameter CNT_W, default 16: width of the flag-stall performance counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
REQ-005 freeze  input  1  pipeline freeze; 1 holds all state.
REQ-006 ex_valid  input  1  EX stage holds a live instruction.
REQ-007 ex_s  input  1  S-bit of EX instruction; 1 = instruction updates flags.
REQ-008 ex_flags  input  4  ALU result flags {N,Z,C,V}.
REQ-009 id_valid  input  1  ID stage holds a live instruction.
REQ-010 id_cond  input  4  condition field of ID instruction.
REQ-011 exc_entry  input  1  exception entry pulse; save flags.
REQ-012 exc_return  input  1  exception return pulse; restore flags.
REQ-013 n, z, c, v  output  1 each  flags presented to the condition checker.
REQ-014 flag_stall  output  1  request to hold IF/ID one cycle.
REQ-015 saved_flags  output  4  saved status {N,Z,C,V}.
REQ-016 stall_count  output  CNT_W  number of flag-stall cycles.

Function
REQ-017 The block SHALL hold a 4-bit status register SR = {N,Z,C,V} and a 4-bit saved register SV (driven on saved_flags).
REQ-018 ex_wr = ex_valid && ex_s; on a rising edge with freeze=0, exc_return=0 and ex_wr=1, SR SHALL load ex_flags.
REQ-019 On a rising edge with freeze=0, exc_return=1 and exc_entry=0, SR SHALL load SV; the same-cycle EX write is discarded (EX is squashed).
REQ-020 On a rising edge with freeze=0 and exc_entry=1, SV SHALL load SR's next value (including a same-cycle ex_wr); a simultaneous exc_return SHALL be ignored.
REQ-021 With no update condition true, SR and SV SHALL hold.
REQ-022 A hazard SHALL be defined as: id_valid=1, id_cond in 0000..1101, and ex_wr=1; conditions 1110 (AL) and 1111 never hazard.
REQ-023 FWD_EN=1: {n,z,c,v} SHALL equal ex_flags when ex_wr=1, else SR, combinationally; flag_stall SHALL be 0 always.
REQ-024 FWD_EN=0: {n,z,c,v} SHALL equal SR; flag_stall SHALL equal the hazard term combinationally (one-cycle stall suffices, SR written at the end of EX).
REQ-025 flag_stall SHALL be evaluated regardless of freeze.
REQ-026 stall_count SHALL increment by 1 on each rising edge with flag_stall=1 and freeze=0, and SHALL saturate at all-ones (no wrap).
REQ-027 freeze=1 SHALL hold SR, SV and stall_count, overriding exc_entry, exc_return and ex_wr.
REQ-028 All outputs SHALL be glitch-free functions of registers and current inputs; no latency beyond one edge for any register update.

Reset
REQ-029 rst=0 SHALL asynchronously clear SR, SV and stall_count to 0; the outputs then follow REQ-023/024 (n,z,c,v=0 when ex_wr=0).
REQ-030 Assertion of rst mid-operation SHALL discard in-flight updates; the first update after release occurs on the first rising edge with rst=1.

Verification
REQ-031 Reset, then ex_wr=1, ex_flags=0100, one edge -> SR=0100; next cycle, ex_wr=0 -> z=1, n=c=v=0.
REQ-032 FWD_EN=0: SR=0000, ex_wr=1 with ex_flags=0100, id_valid=1, id_cond=0000 -> flag_stall=1 and {n,z,c,v}=0000 that cycle; after the edge, ex_wr=0 -> flag_stall=0, z=1, stall_count=1.
REQ-033 FWD_EN=1, same stimulus as REQ-032 -> flag_stall=0 and z=1 in the same cycle; id_cond=1110 with FWD_EN=0 -> flag_stall=0.
REQ-034 Exception flow: SR=1010 with exc_entry=1, one edge -> SV=1010. Then ex_wr=1, ex_flags=0001, one edge -> SR=0001. Then exc_return=1 with ex_wr=1 and ex_flags=0110, one edge -> SR=1010. exc_entry and exc_return together -> SV updated, SR unaffected by the return.
REQ-035 freeze=1 with ex_wr=1, exc_entry=1 and a hazard present -> SR, SV and stall_count unchanged, flag_stall=1 (FWD_EN=0).
REQ-036 CNT_W=4: force 20 consecutive stall cycles -> stall_count holds 1111. Pulse rst=0 between edges -> stall_count=0, SR=0 and SV=0 immediately.
